// File: rtl/rf_level_ctrl_if.sv
// Handshake bundle between rf_level_ctrl and its environment (core, interrupt
// sources, rf_stack). The master modport drives requests; the slave is the controller.
interface rf_level_ctrl_if #(
  parameter int NumLevels = 8,
  parameter int DataWidth = 32
);
  localparam int IndexLevels = $clog2(NumLevels);

  logic [NumLevels-1:0]   irqReq;
  logic                   stall;
  logic                   mret;
  logic [DataWidth-1:0]   pc;
  logic [DataWidth-1:0]   raIn;
  logic [IndexLevels-1:0] level;
  logic                   writeRaEn;
  logic [DataWidth-1:0]   writeRaData;
  logic [NumLevels-1:0]   irqAck;
  logic                   preempt;
  logic                   ret;
  logic [IndexLevels-1:0] depth;
  logic                   error;

  modport master (
    output irqReq, stall, mret, pc, raIn,
    input  level, writeRaEn, writeRaData, irqAck, preempt, ret, depth, error
  );

  modport slave (
    input  irqReq, stall, mret, pc, raIn,
    output level, writeRaEn, writeRaData, irqAck, preempt, ret, depth, error
  );
endinterface

// File: rtl/rf_level_ctrl.sv
// Interrupt level controller: preempts to the highest pending level, saves the
// return address to rf_stack and restores levels on mret. Define
// RF_LEVEL_CTRL_TAIL_CHAIN_EN to chain straight into a pending handler on mret.
module rf_level_ctrl #(
  parameter int NumLevels = 8,
  parameter int DataWidth = 32
) (
  input  logic          clk,
  input  logic          reset,
  rf_level_ctrl_if.slave bus
);
  localparam int IndexLevels = $clog2(NumLevels);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PREEMPT = 2'd1,
    RETURN  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IndexLevels-1:0] level_q, level_d;
  logic [IndexLevels-1:0] depth_q, depth_d;
  logic [IndexLevels-1:0] stack_q [NumLevels-1];
  logic [IndexLevels-1:0] stack_d [NumLevels-1];
  logic                   error_q, error_d;
  logic [DataWidth-1:0]   write_ra_data_q, write_ra_data_d;

  logic [IndexLevels-1:0] target;
  logic                   take_irq;
  logic [IndexLevels-1:0] top_level;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= RUN;
      level_q         <= '0;
      depth_q         <= '0;
      stack_q         <= '{default: '0};
      error_q         <= 1'b0;
      write_ra_data_q <= '0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      depth_q         <= depth_d;
      stack_q         <= stack_d;
      error_q         <= error_d;
      write_ra_data_q <= write_ra_data_d;
    end
  end

  always_comb begin
    target = '0;
    for (int unsigned i = 1; i < NumLevels; i++) begin
      if (bus.irqReq[i]) target = i[IndexLevels-1:0];
    end
    top_level = stack_q[depth_q - IndexLevels'(1)];
    take_irq  = (target > level_q) && !bus.stall;

    state_d         = RUN;
    level_d         = level_q;
    depth_d         = depth_q;
    stack_d         = stack_q;
    error_d         = error_q;
    write_ra_data_d = write_ra_data_q;

    // PREEMPT and RETURN ignore all inputs and fall back to RUN.
    if (state_q == RUN) begin
      if (bus.mret) begin
        if (depth_q == '0) begin
          error_d = 1'b1;
        end else begin
`ifdef RF_LEVEL_CTRL_TAIL_CHAIN_EN
          // Chain: the current level is replaced in place, the saved entry stays put.
          if ((target > top_level) && !bus.stall) begin
            state_d         = PREEMPT;
            level_d         = target;
            write_ra_data_d = bus.raIn;
          end else begin
            state_d = RETURN;
            level_d = top_level;
            depth_d = depth_q - IndexLevels'(1);
          end
`else
          state_d = RETURN;
          level_d = top_level;
          depth_d = depth_q - IndexLevels'(1);
`endif
        end
      end else if (take_irq) begin
        state_d          = PREEMPT;
        stack_d[depth_q] = level_q;
        level_d          = target;
        depth_d          = depth_q + IndexLevels'(1);
        write_ra_data_d  = bus.pc;
      end
    end
  end

  always_comb begin
    bus.level       = level_q;
    bus.depth       = depth_q;
    bus.error       = error_q;
    bus.writeRaData = write_ra_data_q;
    bus.writeRaEn   = (state_q == PREEMPT);
    bus.preempt     = (state_q == PREEMPT);
    bus.ret         = (state_q == RETURN);
    bus.irqAck      = (state_q == PREEMPT) ? (NumLevels'(1) << level_q) : '0;
  end
endmodule

// File: tb/tb_rf_level_ctrl.sv
// Self-checking bench for rf_level_ctrl: directed scenarios then random traffic,
// all compared against a queue-based behavioural model.
module tb_rf_level_ctrl;
  localparam int NumLevels = 8;
  localparam int DataWidth = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_level_ctrl_if #(.NumLevels(NumLevels), .DataWidth(DataWidth)) bus ();
  rf_level_ctrl #(.NumLevels(NumLevels), .DataWidth(DataWidth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: saved levels live in a queue, pulses recomputed per edge.
  int          m_level;
  int          m_stack[$];
  bit          m_err;
  bit          m_busy;
  logic [31:0] m_data;
  bit          m_wen, m_pre, m_ret;
  logic [7:0]  m_ack;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input logic r, input logic [7:0] irq, input logic st,
                                     input logic mr, input logic [31:0] p, input logic [31:0] ra);
    int t;
    m_wen = 0; m_pre = 0; m_ret = 0; m_ack = '0;
    if (!r) begin
      m_level = 0; m_stack.delete(); m_err = 0; m_busy = 0; m_data = '0;
      return;
    end
    if (m_busy) begin
      m_busy = 0;
      return;
    end
    t = 0;
    for (int i = 7; i >= 1; i--) if (irq[i] && t == 0) t = i;
    if (mr) begin
      if (m_stack.size() == 0) m_err = 1;
      else begin
`ifdef RF_LEVEL_CTRL_TAIL_CHAIN_EN
        if (t > m_stack[$] && !st) begin
          m_level = t; m_data = ra; m_wen = 1; m_pre = 1; m_ack = 8'(1 << t); m_busy = 1;
        end else begin
          m_level = m_stack.pop_back(); m_ret = 1; m_busy = 1;
        end
`else
        m_level = m_stack.pop_back(); m_ret = 1; m_busy = 1;
`endif
      end
    end else if (t > m_level && !st) begin
      m_stack.push_back(m_level);
      m_level = t; m_data = p; m_wen = 1; m_pre = 1; m_ack = 8'(1 << t); m_busy = 1;
    end
  endfunction

  task automatic compare_all();
    check("level", 64'(bus.level), 64'(m_level));
    check("depth", 64'(bus.depth), 64'(m_stack.size()));
    check("error", 64'(bus.error), 64'(m_err));
    check("writeRaEn", 64'(bus.writeRaEn), 64'(m_wen));
    check("writeRaData", 64'(bus.writeRaData), 64'(m_data));
    check("irqAck", 64'(bus.irqAck), 64'(m_ack));
    check("preempt", 64'(bus.preempt), 64'(m_pre));
    check("ret", 64'(bus.ret), 64'(m_ret));
  endtask

  task automatic step(input logic r, input logic [7:0] irq, input logic st, input logic mr,
                      input logic [31:0] p, input logic [31:0] ra);
    reset      = r;
    bus.irqReq = irq;
    bus.stall  = st;
    bus.mret   = mr;
    bus.pc     = p;
    bus.raIn   = ra;
    @(posedge clk);
    model_step(r, irq, st, mr, p, ra);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    // Reset and first preemption
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    check("rst_level", 64'(bus.level), 64'd0);
    check("rst_depth", 64'(bus.depth), 64'd0);
    step(1'b1, 8'h08, 1'b0, 1'b0, 32'h100, 32'h0);
    check("pre3_level", 64'(bus.level), 64'd3);
    check("pre3_data", 64'(bus.writeRaData), 64'h100);
    check("pre3_ack", 64'(bus.irqAck), 64'h08);
    idle();

    // Lower request stays pending; stall holds off preemption
    step(1'b1, 8'h04, 1'b0, 1'b0, 32'h110, 32'h0);
    check("low_level", 64'(bus.level), 64'd3);
    step(1'b1, 8'h20, 1'b0, 1'b0, 32'h120, 32'h0);
    check("pre5_depth", 64'(bus.depth), 64'd2);
    idle();
    step(1'b1, 8'h80, 1'b1, 1'b0, 32'h130, 32'h0);
    step(1'b1, 8'h80, 1'b1, 1'b0, 32'h134, 32'h0);
    check("stall_level", 64'(bus.level), 64'd5);
    step(1'b1, 8'h80, 1'b0, 1'b0, 32'h138, 32'h0);
    check("pre7_level", 64'(bus.level), 64'd7);
    idle();

    // Unwind, then underflow
    step(1'b1, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0); idle();
    step(1'b1, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0);
    check("ret3_level", 64'(bus.level), 64'd3);
    check("ret3_ret", 64'(bus.ret), 64'd1);
    idle();
    step(1'b1, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0); idle();
    step(1'b1, 8'h00, 1'b0, 1'b1, 32'h0, 32'h0);
    check("uflow_error", 64'(bus.error), 64'd1);
    check("uflow_level", 64'(bus.level), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // mret coinciding with a pending request
    step(1'b1, 8'h08, 1'b0, 1'b0, 32'h250, 32'h0); idle();
    step(1'b1, 8'h04, 1'b0, 1'b1, 32'h300, 32'h200);
`ifdef RF_LEVEL_CTRL_TAIL_CHAIN_EN
    check("tc_level", 64'(bus.level), 64'd2);
    check("tc_data", 64'(bus.writeRaData), 64'h200);
    check("tc_ack", 64'(bus.irqAck), 64'h04);
    check("tc_depth", 64'(bus.depth), 64'd1);
`else
    check("mret_first_level", 64'(bus.level), 64'd0);
    check("mret_first_ret", 64'(bus.ret), 64'd1);
    step(1'b1, 8'h04, 1'b0, 1'b0, 32'h300, 32'h200);
    step(1'b1, 8'h04, 1'b0, 1'b0, 32'h300, 32'h200);
    check("after_ret_level", 64'(bus.level), 64'd2);
    check("after_ret_data", 64'(bus.writeRaData), 64'h300);
`endif
    idle();

    // Reset while in PREEMPT
    step(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0); idle();
    step(1'b1, 8'h40, 1'b0, 1'b0, 32'h400, 32'h0);
    step(1'b0, 8'h40, 1'b0, 1'b0, 32'h404, 32'h0);
    check("rstpre_level", 64'(bus.level), 64'd0);
    check("rstpre_ack", 64'(bus.irqAck), 64'd0);
    idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic [7:0] irq;
      r   = ($urandom_range(0, 99) != 0);
      irq = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      step(r, irq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_level_ctrl.md
RF_LEVEL_CTRL -- requirements
Module: rf_level_ctrl

Interface
REQ-001 SHALL have parameter NumLevels, default 8: number of rf_stack levels; level 0 is thread mode.
REQ-002 SHALL have parameter DataWidth, default 32: return-address width.
REQ-003 SHALL derive localparam IndexLevels = $clog2(NumLevels).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 irqReq  in  NumLevels  pending request per level; bit 0 is ignored.
REQ-007 stall  in  1  core cannot accept preemption this cycle.
REQ-008 mret  in  1  return-from-handler request, one-cycle pulse.
REQ-009 pc  in  DataWidth  address to resume at after preemption.
REQ-010 raIn  in  DataWidth  ra of the current level, driven from rf_stack readRa.
REQ-011 level  out  IndexLevels  active level, driven to rf_stack level.
REQ-012 writeRaEn  out  1  ra write strobe to rf_stack.
REQ-013 writeRaData  out  DataWidth  ra write data to rf_stack.
REQ-014 irqAck  out  NumLevels  one-hot acknowledge of the taken request.
REQ-015 preempt  out  1  pulse on level entry; redirects fetch.
REQ-016 ret  out  1  pulse on level restore.
REQ-017 depth  out  IndexLevels  number of saved levels on the internal stack.
REQ-018 error  out  1  sticky underflow flag.

Function
REQ-019 SHALL implement FSM states RUN, PREEMPT and RETURN; each of PREEMPT and RETURN SHALL last exactly one cycle and then go to RUN.
REQ-020 In RUN, target T SHALL be the highest set irqReq bit in 1..NumLevels-1.
REQ-021 Preemption SHALL occur when T > level and stall=0.
REQ-022 Preemption decided at cycle N SHALL, at N+1: enter PREEMPT; push the old level; set level=T; depth+1; writeRaEn=1; writeRaData=pc sampled at N; irqAck=1<<T; preempt=1.
REQ-023 Because levels strictly increase, the stack SHALL hold NumLevels-1 entries and SHALL never overflow.
REQ-024 mret in RUN at cycle N with depth>0 SHALL, at N+1: enter RETURN; pop the stack into level; depth-1; ret=1.
REQ-025 mret in RUN with depth=0 SHALL set error=1 and leave level, depth and the FSM state unchanged.
REQ-026 When mret and a preemption condition occur together, mret SHALL win; irqReq SHALL be re-evaluated in RUN after RETURN.
REQ-027 mret, irqReq and stall SHALL be ignored in PREEMPT and RETURN.
REQ-028 writeRaEn, irqAck, preempt and ret SHALL each be single-cycle pulses; writeRaData SHALL hold its last value when writeRaEn=0.
REQ-029 irqReq bits at or below level SHALL stay pending and SHALL NOT be acknowledged.

Reset
REQ-030 With reset=0 at a clock edge, the block SHALL set: state=RUN, level=0, depth=0, stack cleared, error=0, all pulses=0, writeRaData=0.
REQ-031 Reset asserted during PREEMPT or RETURN SHALL abort the operation with no further ack or pulse.

Configuration
REQ-032 Macro RF_LEVEL_CTRL_TAIL_CHAIN_EN SHALL select tail-chaining.
REQ-033 With the macro defined: when mret at cycle N has a popped level P and T > P with stall=0, cycle N+1 SHALL enter PREEMPT with level=T, stack and depth unchanged, writeRaData=raIn sampled at N, writeRaEn=1, irqAck=1<<T, preempt=1, ret=0.
REQ-034 Without the macro: REQ-026 behaviour (RETURN first, preemption evaluated afterwards).

Verification
REQ-035 reset=0 for 2 cycles, then reset=1 -> level=0, depth=0, error=0, no pulses.
REQ-036 Level 0, pc=0x100, irqReq=0x08 -> next cycle level=3, writeRaEn=1, writeRaData=0x100, irqAck=0x08, preempt=1, depth=1.
REQ-037 Level 3: irqReq=0x04 -> no change; then irqReq=0x20 -> level=5, depth=2; with stall=1 and irqReq=0x80 -> no change until stall=0.
REQ-038 mret at level 5, depth 2 -> level=3, ret=1, depth=1; mret at depth 0 -> error=1, level unchanged.
REQ-039 Level 3 with stack [0], mret plus irqReq=0x04, raIn=0x200, pc=0x300 -> with macro: level=2, writeRaData=0x200, irqAck=0x04, depth=1; without macro: level=0, ret=1, then level=2, writeRaData=0x300, depth=1.
REQ-040 reset=0 during PREEMPT -> next cycle level=0, depth=0, irqAck=0.
